mem_port_arbiter: RTL and testbench

- Shares one single-port, synchronous, 1-cycle-read-latency word RAM between the core's instruction-fetch port and data port.
- Sits between top_riscV's IMEM/DMEM interfaces and the unified test/boot RAM.
- Data accesses have priority; a streak counter guarantees fetch forward progress.
- Out-of-range addresses are flagged instead of aliasing.

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 1-cycle-latency word RAM between fetch and data ports; data wins
// unless MAX_DATA_STREAK data grants in a row have starved a pending fetch.
module mem_port_arbiter #(
  parameter int MEM_ADDR_WIDTH  = 13,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [31:0]               if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [3:0]                d_be,
  input  logic [31:0]               d_addr,
  input  logic [31:0]               d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [31:0]               d_rdata,
  output logic                      addr_err,
  output logic                      ram_en,
  output logic [3:0]                ram_we,
  output logic [MEM_ADDR_WIDTH-3:0] ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  logic [SW-1:0] streak_q, streak_d;
  owner_e        owner_q, owner_d;
  logic          err_q, err_d;
  logic [31:0]   if_hold_q, if_hold_d;
  logic [31:0]   d_hold_q, d_hold_d;

  logic          sel_if, sel_d, gnt_any, oor;
  logic [31:0]   sel_addr;
  logic [31:0]   resp_data;
  logic          addr_lsb_unused;

  // Request side: arbitration, address decode and RAM drive.
  always_comb begin
    sel_if    = if_req && (!d_req || streak_q == STREAK_MAX);
    sel_d     = d_req && !sel_if;
    if_gnt    = reset_n && sel_if;
    d_gnt     = reset_n && sel_d;
    gnt_any   = if_gnt || d_gnt;
    sel_addr  = sel_if ? if_addr : d_addr;
    oor       = |sel_addr[31:MEM_ADDR_WIDTH];
    ram_en    = gnt_any && !oor;
    ram_we    = (ram_en && d_gnt && d_we) ? d_be : 4'h0;
    ram_addr  = gnt_any ? sel_addr[MEM_ADDR_WIDTH-1:2] : '0;
    ram_wdata = (d_gnt && d_we) ? d_wdata : 32'h0;
    addr_lsb_unused = ^sel_addr[1:0];
  end

  // Response side: out-of-range reads answer with zero data.
  always_comb begin
    resp_data = err_q ? 32'h0 : ram_rdata;
    if_rvalid = reset_n && (owner_q == OWN_IF);
    d_rvalid  = reset_n && (owner_q == OWN_D);
    addr_err  = reset_n && err_q;
    if_rdata  = if_rvalid ? resp_data : if_hold_q;
    d_rdata   = d_rvalid ? resp_data : d_hold_q;
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (d_gnt && streak_q < STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end

    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end

    err_d     = gnt_any && oor;
    if_hold_d = if_rdata;
    d_hold_d  = d_rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      streak_q  <= '0;
      owner_q   <= OWN_NONE;
      err_q     <= 1'b0;
      if_hold_q <= 32'h0;
      d_hold_q  <= 32'h0;
    end else begin
      streak_q  <= streak_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      if_hold_q <= if_hold_d;
      d_hold_q  <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: owns the RAM, drives vectors, directed and random traffic.
module tb_mem_port_arbiter;
  localparam int AW    = 13;
  localparam int MAXS  = 4;
  localparam int WORDS = 1 << (AW - 2);

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, addr_err;
  logic [31:0] if_rdata, d_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [AW-3:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_ADDR_WIDTH(AW), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .addr_err(addr_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAAAAAAAA;
    return 32'h5A00_0000 ^ (i * 32'h0001_0101);
  endfunction

  // Single-port synchronous RAM with byte enables and 1-cycle read latency.
  logic [31:0] mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    ram_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [WORDS];
  int          ref_streak;
  bit          exp_if_rv, exp_d_rv, exp_err;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ref_streak   = 0;
    exp_if_rv    = 0;
    exp_d_rv     = 0;
    exp_err      = 0;
    exp_if_rdata = 32'h0;
    exp_d_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; d_be = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive inputs, check last cycle's response and this cycle's grant.
  task automatic step(input bit ifr, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
    bit g_if, g_d, oor;
    logic [31:0] a;
    int idx;
    @(posedge clk); #1;
    if_req = ifr; if_addr = ia; d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    #2;
    check("if_rvalid", if_rvalid, exp_if_rv);
    check("d_rvalid", d_rvalid, exp_d_rv);
    check("addr_err", addr_err, exp_err);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);

    g_if = ifr && (!dr || ref_streak == MAXS);
    g_d  = dr && !g_if;
    a    = g_if ? ia : da;
    oor  = (a >> AW) != 0;
    idx  = int'(a[AW-1:2]);
    check("if_gnt", if_gnt, g_if);
    check("d_gnt", d_gnt, g_d);
    check("ram_en", ram_en, (g_if || g_d) && !oor);
    check("ram_we", ram_we, (g_d && dwe && !oor) ? dbe : 4'h0);
    if ((g_if || g_d) && !oor) check("ram_addr", ram_addr, a[AW-1:2]);
    if (g_d && dwe && !oor) check("ram_wdata", ram_wdata, dwd);

    exp_if_rv = 0; exp_d_rv = 0;
    exp_err = (g_if || g_d) && oor;
    if (g_if) begin
      exp_if_rv = 1;
      exp_if_rdata = oor ? 32'h0 : ref_mem[idx];
    end else if (g_d && !dwe) begin
      exp_d_rv = 1;
      exp_d_rdata = oor ? 32'h0 : ref_mem[idx];
    end else if (g_d && !oor) begin
      for (int b = 0; b < 4; b++)
        if (dbe[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
    end

    if (!ifr || g_if) ref_streak = 0;
    else if (g_d && ref_streak < MAXS) ref_streak++;
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  typedef struct {
    bit ifr; logic [31:0] ia; bit dr; bit dwe; logic [3:0] dbe; logic [31:0] da; logic [31:0] dwd;
    bit e_ifg; bit e_dg; bit e_en; logic [3:0] e_we; logic [10:0] e_addr;
  } vec_t;

  vec_t vt [10];
  bit   pat [10];

  initial begin
    int bad;
    bit rifr, rdr, rwe;
    logic [31:0] ria, rda;

    vt[0] = '{1, 32'h10,        0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 1, 4'h0, 11'h004};
    vt[1] = '{0, 32'h0,         1, 0, 4'h0, 32'h20,   32'h0,        0, 1, 1, 4'h0, 11'h008};
    vt[2] = '{0, 32'h0,         1, 1, 4'h5, 32'h1FFC, 32'hCAFEF00D, 0, 1, 1, 4'h5, 11'h7FF};
    vt[3] = '{1, 32'h80,        1, 0, 4'h0, 32'h44,   32'h0,        0, 1, 1, 4'h0, 11'h011};
    vt[4] = '{0, 32'h0,         1, 0, 4'h0, 32'h4000, 32'h0,        0, 1, 0, 4'h0, 11'h000};
    vt[5] = '{1, 32'h8000_0000, 0, 0, 4'h0, 32'h0,    32'h0,        1, 0, 0, 4'h0, 11'h000};
    vt[6] = '{0, 32'h0,         0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 4'h0, 11'h000};
    vt[7] = '{0, 32'h0,         1, 1, 4'h0, 32'h30,   32'h12345678, 0, 1, 1, 4'h0, 11'h00C};
    vt[8] = '{0, 32'h0,         1, 0, 4'h0, 32'h23,   32'h0,        0, 1, 1, 4'h0, 11'h008};
    vt[9] = '{1, 32'h8000_0000, 1, 0, 4'h0, 32'h48,   32'h0,        0, 1, 1, 4'h0, 11'h012};
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    reset_n = 0;
    if_req = 0; d_req = 0; d_we = 0; d_be = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    model_reset();

    // Reset state with requests asserted: nothing may leak out.
    @(posedge clk); #1;
    if_req = 1; d_req = 1; if_addr = 32'h10; d_addr = 32'h20;
    @(posedge clk); #3;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    do_reset();

    // Fetch of word 4
    step(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    check("A_if_gnt", if_gnt, 1);
    idle();
    check("A_if_rvalid", if_rvalid, 1);
    check("A_if_rdata", if_rdata, 32'hDEADBEEF);
    check("A_d_rvalid", d_rvalid, 0);

    // Partial write then read back
    step(0, 32'h0, 1, 1, 4'b0011, 32'h20, 32'h11223344);
    step(0, 32'h0, 1, 0, 4'h0, 32'h20, 32'h0);
    check("B_wr_no_rvalid", d_rvalid, 0);
    idle();
    check("B_d_rvalid", d_rvalid, 1);
    check("B_d_rdata", d_rdata, 32'hAAAA3344);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      step(vt[i].ifr, vt[i].ia, vt[i].dr, vt[i].dwe, vt[i].dbe, vt[i].da, vt[i].dwd);
      check($sformatf("V%0d_if_gnt", i), if_gnt, vt[i].e_ifg);
      check($sformatf("V%0d_d_gnt", i), d_gnt, vt[i].e_dg);
      check($sformatf("V%0d_ram_en", i), ram_en, vt[i].e_en);
      check($sformatf("V%0d_ram_we", i), ram_we, vt[i].e_we);
      if (vt[i].e_en) check($sformatf("V%0d_ram_addr", i), ram_addr, vt[i].e_addr);
      idle();
    end

    // Starvation bound: D D D D IF repeating
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h100, 1, 0, 4'h0, 32'h0C, 32'h0);
      check($sformatf("C%0d_d_gnt", i), d_gnt, pat[i]);
      check($sformatf("C%0d_if_gnt", i), if_gnt, !pat[i]);
    end
    idle();

    // Back-to-back reads on different ports
    step(0, 32'h0, 1, 0, 4'h0, 32'h04, 32'h0);
    step(1, 32'h08, 0, 0, 4'h0, 32'h0, 32'h0);
    check("D_d_rvalid", d_rvalid, 1);
    check("D_d_rdata", d_rdata, init_word(1));
    check("D_if_rvalid0", if_rvalid, 0);
    idle();
    check("D_if_rvalid", if_rvalid, 1);
    check("D_if_rdata", if_rdata, init_word(2));
    check("D_d_rvalid_pulse", d_rvalid, 0);
    check("D_d_rdata_hold", d_rdata, init_word(1));

    // Out-of-range read
    step(0, 32'h0, 1, 0, 4'h0, 32'h4000, 32'h0);
    check("E_d_gnt", d_gnt, 1);
    check("E_ram_en", ram_en, 0);
    idle();
    check("E_addr_err", addr_err, 1);
    check("E_d_rvalid", d_rvalid, 1);
    check("E_d_rdata", d_rdata, 32'h0);
    idle();
    check("E_addr_err_pulse", addr_err, 0);

    // Reset right after a read grant drops the response and the streak
    step(1, 32'h100, 1, 0, 4'h0, 32'h40, 32'h0);
    step(1, 32'h100, 1, 0, 4'h0, 32'h0C, 32'h0);
    check("F_d_gnt", d_gnt, 1);
    reset_n = 0;
    @(posedge clk); #3;
    check("F_if_rvalid", if_rvalid, 0);
    check("F_d_rvalid", d_rvalid, 0);
    check("F_addr_err", addr_err, 0);
    check("F_d_gnt_rst", d_gnt, 0);
    check("F_ram_en", ram_en, 0);
    check("F_if_rdata", if_rdata, 0);
    check("F_d_rdata", d_rdata, 0);
    if_req = 0; d_req = 0;
    reset_n = 1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h100, 1, 0, 4'h0, 32'h0C, 32'h0);
      check($sformatf("F%0d_d_gnt", i), d_gnt, pat[i]);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rifr = ($urandom_range(0, 3) != 0);
        rdr  = ($urandom_range(0, 3) != 0);
        rwe  = $urandom_range(0, 1);
        ria  = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h2000) : 32'($urandom_range(0, 8191));
        rda  = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h2000) : 32'($urandom_range(0, 8191));
        step(rifr, ria, rdr, rwe, 4'($urandom_range(0, 15)), rda, $urandom);
      end
    end
    idle();

    bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("ram_contents_bad_words", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
